fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 9-bit pipelined CPU. It owns the program counter, addresses the external combinational instruction ROM, and hands one 9-bit instruction per cycle to the decode stage (`Control_Unit`). It squashes wrong-path instructions on taken branches and freezes on stalls. It also runs the halt sequence: stop fetching, drain the pipeline, then raise `done`.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 9-bit pipelined CPU.
//   - default PC / instruction widths
//   - opcode constants and the bubble (NOP) encoding
//   - fetch-stage state enumeration
package cpu_pkg;

   localparam int PC_WIDTH    = 10;
   localparam int INSTR_WIDTH = 9;

   // 5-bit major opcodes that the fetch/decode boundary cares about
   localparam logic [4:0] OP_HALT = 5'b11010;
   localparam logic [4:0] OP_NOP  = 5'b11011;

   // Bubble: reserved NOP opcode with zero operand field
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = {OP_NOP, 4'b0000};

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline boundary register carrying {instruction, pc, valid}.
//   Priority: reset > flush > hold > load.
//   flush loads a bubble (NOP_INSTR, valid=0) but still records pc_in.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   hold              keep current contents
//   flush             insert a bubble
//   instr_in, pc_in   incoming instruction and its PC
//   instr, pc, valid  registered outputs
module if_id_reg #(
   parameter int                     INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
   parameter int                     PC_WIDTH    = cpu_pkg::PC_WIDTH,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hold,
   input  logic                   flush,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   input  logic [PC_WIDTH-1:0]    pc_in,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   valid
);

   logic [INSTR_WIDTH-1:0] instr_p1;
   logic [PC_WIDTH-1:0]    pc_p1;
   logic                   vld_p1;

   // IF -> ID boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_p1 <= NOP_INSTR;
         pc_p1    <= '0;
         vld_p1   <= 1'b0;
      end else if (flush) begin
         instr_p1 <= NOP_INSTR;
         pc_p1    <= pc_in;
         vld_p1   <= 1'b0;
      end else if (!hold) begin
         instr_p1 <= instr_in;
         pc_p1    <= pc_in;
         vld_p1   <= 1'b1;
      end
   end

   assign instr = instr_p1;
   assign pc    = pc_p1;
   assign valid = vld_p1;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch + IF/ID register for the 9-bit CPU.
//   Owns the PC, addresses a combinational ROM, squashes wrong-path
//   instructions on taken branches, freezes on stall, and runs the halt
//   sequence (stop fetch, drain, raise done).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   halt_req                       halt instruction is in ID
//   stall                          hold PC and IF/ID this cycle
//   branch_taken, branch_target    redirect from EX
//   rom_addr / rom_data            ROM address (= PC) and same-cycle word
//   instruction_out, pc_out,
//   valid_out                      IF/ID contents to decode
//   done                           halt complete, held until reset
module fetch_stage #(
   parameter int                     PC_WIDTH     = cpu_pkg::PC_WIDTH,
   parameter int                     INSTR_WIDTH  = cpu_pkg::INSTR_WIDTH,
   parameter int                     DRAIN_CYCLES = 3,
   parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = cpu_pkg::NOP_INSTR
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   halt_req,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    rom_addr,
   input  logic [INSTR_WIDTH-1:0] rom_data,
   output logic [INSTR_WIDTH-1:0] instruction_out,
   output logic [PC_WIDTH-1:0]    pc_out,
   output logic                   valid_out,
   output logic                   done
);

   import cpu_pkg::*;

   localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

   fetch_state_t         state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]  pc_p0, pc_d;
   logic                 done_q;
   logic                 hold, flush;

   // PC / FSM registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         pc_p0   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_p0   <= pc_d;
         // One edge after entering HALTED, so done lands DRAIN_CYCLES+1
         // edges after the halt is sampled (also for DRAIN_CYCLES = 0).
         done_q  <= (state_q == HALTED);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_p0;
      hold    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         RUN: begin
            if (branch_taken) begin
               // Branch wins over stall and over a same-cycle (wrong-path) halt
               pc_d  = branch_target;
               flush = 1'b1;
            end else if (halt_req) begin
               flush = 1'b1;
               if (DRAIN_CYCLES == 0) begin
                  state_d = HALTED;
               end else begin
                  state_d = DRAIN;
                  cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
               end
            end else if (stall) begin
               hold = 1'b1;
            end else begin
               pc_d = pc_p0 + PC_WIDTH'(1);
            end
         end
         DRAIN: begin
            flush = 1'b1;
            if (cnt_q == '0) begin
               state_d = HALTED;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HALTED: begin
            hold = 1'b1;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   if_id_reg #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .PC_WIDTH    (PC_WIDTH),
      .NOP_INSTR   (NOP_INSTR)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .hold     (hold),
      .flush    (flush),
      .instr_in (rom_data),
      .pc_in    (pc_p0),
      .instr    (instruction_out),
      .pc       (pc_out),
      .valid    (valid_out)
   );

   assign rom_addr = pc_p0;
   assign done     = done_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic       halt_req;
   logic       stall;
   logic       branch_taken;
   logic [9:0] branch_target;
   logic [9:0] rom_addr;
   logic [8:0] rom_data;
   logic [8:0] instruction_out;
   logic [9:0] pc_out;
   logic       valid_out;
   logic       done;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // ROM[i] = i + 0x10 (truncated to 9 bits)
   always_comb rom_data = 9'(rom_addr + 10'h010);

   fetch_stage #(
      .PC_WIDTH     (10),
      .INSTR_WIDTH  (9),
      .DRAIN_CYCLES (3),
      .NOP_INSTR    (9'b110110000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .halt_req        (halt_req),
      .stall           (stall),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .rom_addr        (rom_addr),
      .rom_data        (rom_data),
      .instruction_out (instruction_out),
      .pc_out          (pc_out),
      .valid_out       (valid_out),
      .done            (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_if(input string tag, input logic [8:0] ins, input logic [9:0] pc,
                         input logic vld);
      chk({tag, ".instr"}, 32'(instruction_out), 32'(ins));
      chk({tag, ".pc"},    32'(pc_out),          32'(pc));
      chk({tag, ".valid"}, 32'(valid_out),       32'(vld));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".rom_addr"}, 32'(rom_addr), 32'h0);
      chk_if(tag, 9'h1B0, 10'h0, 1'b0);
      chk({tag, ".done"}, 32'(done), 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; halt_req = 1'b0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = '0;
      step();
      step();
      chk_reset("rst");
      reset = 1'b0;

      // Free-running fetch
      for (int i = 0; i < 5; i++) begin
         step();
         chk_if("run", 9'(9'h010 + i), 10'(i), 1'b1);
         chk("run.rom_addr", 32'(rom_addr), 32'(i + 1));
      end

      // Stall at PC=3
      do_reset();
      step(); step(); step();
      chk("stl.pre_addr", 32'(rom_addr), 32'h3);
      stall = 1'b1;
      step();
      chk("stl1.addr", 32'(rom_addr), 32'h3);
      chk_if("stl1", 9'h012, 10'h2, 1'b1);
      step();
      chk("stl2.addr", 32'(rom_addr), 32'h3);
      chk_if("stl2", 9'h012, 10'h2, 1'b1);
      stall = 1'b0;
      step();
      chk_if("stl.resume", 9'h013, 10'h3, 1'b1);
      chk("stl.resume_addr", 32'(rom_addr), 32'h4);

      // Branch at PC=7 to 0x2A
      step(); step(); step();
      chk("br.pre_addr", 32'(rom_addr), 32'h7);
      branch_taken = 1'b1; branch_target = 10'h02A;
      step();
      branch_taken = 1'b0;
      chk_if("br.bubble", 9'h1B0, 10'h7, 1'b0);
      chk("br.addr", 32'(rom_addr), 32'h2A);
      step();
      chk_if("br.target", 9'h03A, 10'h02A, 1'b1);

      // Branch with simultaneous stall and halt: branch wins, no halt
      branch_taken = 1'b1; branch_target = 10'h02A; stall = 1'b1; halt_req = 1'b1;
      step();
      branch_taken = 1'b0; stall = 1'b0; halt_req = 1'b0;
      chk_if("br2.bubble", 9'h1B0, 10'h02B, 1'b0);
      chk("br2.addr", 32'(rom_addr), 32'h2A);
      step();
      chk_if("br2.target", 9'h03A, 10'h02A, 1'b1);
      chk("br2.addr_next", 32'(rom_addr), 32'h2B);
      step(); step(); step(); step();
      chk("br2.no_done", 32'(done), 32'h0);
      chk("br2.running", 32'(valid_out), 32'h1);

      // Halt at PC=5
      do_reset();
      for (int i = 0; i < 5; i++) step();
      chk("hlt.pre_addr", 32'(rom_addr), 32'h5);
      halt_req = 1'b1;
      step();                                   // sampling edge
      halt_req = 1'b0;
      chk("hlt.e0.addr", 32'(rom_addr), 32'h5);
      chk("hlt.e0.valid", 32'(valid_out), 32'h0);
      chk("hlt.e0.done", 32'(done), 32'h0);
      for (int e = 1; e <= 3; e++) begin
         branch_taken = (e == 2); branch_target = 10'h100;
         halt_req = (e == 1); stall = (e == 3);
         step();
         chk("hlt.drain.addr", 32'(rom_addr), 32'h5);
         chk("hlt.drain.valid", 32'(valid_out), 32'h0);
         chk("hlt.drain.done", 32'(done), 32'h0);
      end
      branch_taken = 1'b0; halt_req = 1'b0; stall = 1'b0;
      step();                                   // 4th edge after sample
      chk("hlt.done", 32'(done), 32'h1);
      chk("hlt.addr", 32'(rom_addr), 32'h5);
      branch_taken = 1'b1; branch_target = 10'h100;
      step();
      branch_taken = 1'b0;
      chk("hlt.br_ign.addr", 32'(rom_addr), 32'h5);
      chk("hlt.br_ign.done", 32'(done), 32'h1);
      chk("hlt.br_ign.valid", 32'(valid_out), 32'h0);

      // Reset while HALTED
      reset = 1'b1;
      step();
      chk_reset("rst_halted");
      reset = 1'b0;
      step();
      chk_if("rst_halted.restart", 9'h010, 10'h0, 1'b1);

      // Reset while in DRAIN
      do_reset();
      step(); step();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk_reset("rst_drain");
      reset = 1'b0;
      step();
      chk_if("rst_drain.restart", 9'h010, 10'h0, 1'b1);
      for (int i = 0; i < 6; i++) step();
      chk("rst_drain.no_done", 32'(done), 32'h0);
      chk("rst_drain.addr", 32'(rom_addr), 32'h7);

      // PC wrap at 0x3FF
      branch_taken = 1'b1; branch_target = 10'h3FF;
      step();
      branch_taken = 1'b0;
      chk("wrap.pre_addr", 32'(rom_addr), 32'h3FF);
      step();
      chk("wrap.addr", 32'(rom_addr), 32'h000);
      chk_if("wrap", 9'h00F, 10'h3FF, 1'b1);
      step();
      chk_if("wrap.after", 9'h010, 10'h000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
